// File: rtl/bus_slave_sel_pkg.sv
//------------------------------------------------------------------------------
// Module   : bus_slave_sel_pkg
// Brief    : Shared bus header: state encodings, bus size defaults and
//            active-low enable/disable levels.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bus_slave_sel_pkg;

  // Default bus geometry
  localparam int c_slave_num_def = 8;
  localparam int c_addr_w_def    = 30;

  // Active-low signal levels
  localparam logic c_en_n  = 1'b0;
  localparam logic c_dis_n = 1'b1;

  // Slave-select FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bus_slave_sel_if.sv
//------------------------------------------------------------------------------
// Module   : bus_slave_sel_if
// Brief    : Master/slave-select bus bundle: address strobe, per-slave chip
//            selects and readies, master ready and error reporting.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bus_slave_sel_if
  import bus_slave_sel_pkg::*;
#(
  parameter int SLAVE_NUM = c_slave_num_def,
  parameter int ADDR_W    = c_addr_w_def
);
  localparam int IDX_W = $clog2(SLAVE_NUM);

  logic [ADDR_W-1:0]    s_addr;
  logic                 s_as_;
  logic [SLAVE_NUM-1:0] s_rdy_;
  logic [SLAVE_NUM-1:0] s_cs_;
  logic [IDX_W-1:0]     s_sel;
  logic                 m_rdy_;
  logic                 bus_err;
  logic                 busy;

  // Decoder side
  modport slave (
    input  s_addr, s_as_, s_rdy_,
    output s_cs_, s_sel, m_rdy_, bus_err, busy
  );

  // Bus master / slave-array side
  modport master (
    output s_addr, s_as_, s_rdy_,
    input  s_cs_, s_sel, m_rdy_, bus_err, busy
  );

endinterface

`default_nettype wire

// File: rtl/bus_tmo_cnt.sv
//------------------------------------------------------------------------------
// Module   : bus_tmo_cnt
// Brief    : Access timeout counter. Clears while clr is high, counts while
//            en is high, saturates at TIMEOUT-1 and flags expiry there.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_tmo_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count access cycles; hold at the last value so the count never wraps
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != c_last)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/bus_slave_sel.sv
//------------------------------------------------------------------------------
// Module   : bus_slave_sel
// Brief    : Decodes the master address into a registered one-cold slave
//            chip select, waits for that slave's ready (with timeout) and
//            returns a one-cycle master ready or bus error pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_slave_sel
  import bus_slave_sel_pkg::*;
#(
  parameter int                   SLAVE_NUM = c_slave_num_def,
  parameter int                   ADDR_W    = c_addr_w_def,
  parameter int                   TIMEOUT   = 255,
  parameter logic [SLAVE_NUM-1:0] SLAVE_EN  = '1
) (
  input  logic           clk,
  input  logic           reset,
  bus_slave_sel_if.slave bus
);
  localparam int IDX_W = $clog2(SLAVE_NUM);

  state_t               r_state;
  logic [SLAVE_NUM-1:0] r_cs_;
  logic [IDX_W-1:0]     r_sel;
  logic                 r_m_rdy_;
  logic                 r_bus_err;
  logic                 r_busy;

  logic [IDX_W-1:0]     w_idx;
  logic [SLAVE_NUM-1:0] w_dec_cs_;
  logic                 w_present;
  logic                 w_sel_rdy;
  logic                 w_in_access;
  logic                 w_expired;
  logic                 w_unused_addr;

  // Slave index lives in the top address bits; the rest is the slave's own
  assign w_idx         = bus.s_addr[ADDR_W-1 -: IDX_W];
  assign w_unused_addr = ^bus.s_addr[ADDR_W-IDX_W-1:0];
  assign w_present     = SLAVE_EN[w_idx];

  // Only the selected slave's ready is looked at
  assign w_sel_rdy   = (bus.s_rdy_[r_sel] == c_en_n);
  assign w_in_access = (r_state == ST_ACCESS);

  // One-cold chip-select decode of the incoming index
  for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_cs_dec
    assign w_dec_cs_[i] = (w_idx == IDX_W'(i)) ? c_en_n : c_dis_n;
  end

  // Counter is held clear outside ACCESS, so it restarts at 0 on every entry
  bus_tmo_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (!w_in_access),
    .en      (w_in_access),
    .expired (w_expired)
  );

  // Select FSM with all bus outputs registered; pulses default to inactive
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cs_     <= {SLAVE_NUM{c_dis_n}};
      r_sel     <= '0;
      r_m_rdy_  <= c_dis_n;
      r_bus_err <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_m_rdy_  <= c_dis_n;
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
          r_cs_   <= {SLAVE_NUM{c_dis_n}};
          r_busy  <= 1'b0;
          if (bus.s_as_ == c_en_n) begin
            r_sel <= w_idx;
            if (w_present) begin
              r_state <= ST_ACCESS;
              r_cs_   <= w_dec_cs_;
              r_busy  <= 1'b1;
            end else begin
              r_state   <= ST_ERR;
              r_m_rdy_  <= c_en_n;
              r_bus_err <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          // Ready takes priority over a timeout in the same cycle
          if (w_sel_rdy) begin
            r_state  <= ST_DONE;
            r_cs_    <= {SLAVE_NUM{c_dis_n}};
            r_busy   <= 1'b0;
            r_m_rdy_ <= c_en_n;
          end else if (w_expired) begin
            r_state   <= ST_ERR;
            r_cs_     <= {SLAVE_NUM{c_dis_n}};
            r_busy    <= 1'b0;
            r_m_rdy_  <= c_en_n;
            r_bus_err <= 1'b1;
          end
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cs_   <= {SLAVE_NUM{c_dis_n}};
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_cs_   = r_cs_;
  assign bus.s_sel   = r_sel;
  assign bus.m_rdy_  = r_m_rdy_;
  assign bus.bus_err = r_bus_err;
  assign bus.busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_bus_slave_sel.sv
//------------------------------------------------------------------------------
// Module   : tb_bus_slave_sel
// Brief    : Self-checking bench for bus_slave_sel (8 slaves, slave 7 absent,
//            timeout 16) using a transaction-level latency model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_slave_sel;

  localparam int         NS   = 8;
  localparam int         AW   = 30;
  localparam int         TMO  = 16;
  localparam logic [7:0] SLEN = 8'b0111_1111;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bus_slave_sel_if #(.SLAVE_NUM(NS), .ADDR_W(AW)) bus ();

  bus_slave_sel #(
    .SLAVE_NUM (NS),
    .ADDR_W    (AW),
    .TIMEOUT   (TMO),
    .SLAVE_EN  (SLEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Compare every output against the expected bus state of this cycle
  task automatic chk(input string tag, input logic [7:0] e_cs, input logic [2:0] e_sel,
                     input logic e_mrdy, input logic e_err, input logic e_busy);
    n_cmp++;
    assert (bus.s_cs_ === e_cs) else begin
      n_fail++; $error("FAIL %s s_cs_ observed=%h expected=%h", tag, bus.s_cs_, e_cs);
    end
    n_cmp++;
    assert (bus.s_sel === e_sel) else begin
      n_fail++; $error("FAIL %s s_sel observed=%0d expected=%0d", tag, bus.s_sel, e_sel);
    end
    n_cmp++;
    assert (bus.m_rdy_ === e_mrdy) else begin
      n_fail++; $error("FAIL %s m_rdy_ observed=%b expected=%b", tag, bus.m_rdy_, e_mrdy);
    end
    n_cmp++;
    assert (bus.bus_err === e_err) else begin
      n_fail++; $error("FAIL %s bus_err observed=%b expected=%b", tag, bus.bus_err, e_err);
    end
    n_cmp++;
    assert (bus.busy === e_busy) else begin
      n_fail++; $error("FAIL %s busy observed=%b expected=%b", tag, bus.busy, e_busy);
    end
    n_cmp++;
    assert ($countones(~bus.s_cs_) <= 1) else begin
      n_fail++; $error("FAIL %s cs_onecold observed=%h expected=at most one low bit", tag, bus.s_cs_);
    end
  endtask

  task automatic strobe(input int idx);
    logic [2:0] ix;
    ix         = idx[2:0];
    bus.s_addr = {ix, 27'($urandom)};
    bus.s_as_  = 1'b0;
    bus.s_rdy_ = 8'hFF;
  endtask

  // One access: slave idx, selected slave ready in ACCESS cycle rdy_at
  // (outside 1..TMO means never). Expected behaviour from latency rules:
  // absent -> error 1 cycle after strobe; ready in cycle r -> m_rdy_ in r+1;
  // no ready -> error TMO+1 cycles after strobe. next_idx>=0 chains a strobe
  // in the DONE cycle; pre=1 means the strobe was already issued.
  task automatic access(input int idx, input int rdy_at, input int next_idx, input bit pre);
    logic       ok;
    int         last;
    logic [7:0] cs_on;
    logic [7:0] rdy;
    logic [2:0] sel;
    ok    = SLEN[idx] && (rdy_at >= 1) && (rdy_at <= TMO);
    last  = !SLEN[idx] ? 0 : (ok ? rdy_at : TMO);
    sel   = idx[2:0];
    cs_on = 8'hFF;
    cs_on[idx] = 1'b0;
    if (!pre) strobe(idx);
    for (int c = 1; c <= last + 2; c++) begin
      @(negedge clk);
      if (c <= last)
        chk($sformatf("acc%0d_c%0d", idx, c), cs_on, sel, 1'b1, 1'b0, 1'b1);
      else if (c == last + 1)
        chk($sformatf("end%0d_c%0d", idx, c), 8'hFF, sel, 1'b0, !ok, 1'b0);
      else
        chk($sformatf("idle%0d_c%0d", idx, c), 8'hFF, sel, 1'b1, 1'b0, 1'b0);
      if (c <= last) begin
        // Strobe/address noise and foreign readies must be ignored
        bus.s_as_  = 1'($urandom_range(0, 1));
        bus.s_addr = AW'($urandom);
        rdy        = 8'($urandom);
        if (c == 1) rdy[(idx + 1) % NS] = 1'b0;
        rdy[idx]   = (c == rdy_at) ? 1'b0 : 1'b1;
        bus.s_rdy_ = rdy;
      end else if (c == last + 1) begin
        if (!ok) begin
          bus.s_as_  = 1'($urandom_range(0, 1));
          bus.s_addr = AW'($urandom);
          bus.s_rdy_ = 8'($urandom);
        end else if (next_idx >= 0) begin
          strobe(next_idx);
          return;
        end else begin
          bus.s_as_  = 1'b1;
          bus.s_rdy_ = 8'hFF;
        end
      end else begin
        bus.s_as_  = 1'b1;
        bus.s_rdy_ = 8'hFF;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed scenarios followed by randomized accesses
  initial begin
    reset      = 1'b0;
    bus.s_addr = '0;
    bus.s_as_  = 1'b1;
    bus.s_rdy_ = 8'hFF;
    repeat (3) @(negedge clk);
    chk("reset", 8'hFF, 3'd0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 8'hFF, 3'd0, 1'b1, 1'b0, 1'b0);

    // Normal access to slave 2 at the reference address
    bus.s_addr = 30'h1000_0000;
    bus.s_as_  = 1'b0;
    access(2, 3, -1, 1);
    // Timeout on slave 1
    access(1, 0, -1, 0);
    // Absent slave 7
    access(7, 2, -1, 0);
    // Ready in the timeout cycle wins
    access(2, TMO, -1, 0);
    // Back-to-back: slave 0 then slave 5 strobed in DONE
    access(0, 2, 5, 0);
    access(5, 4, -1, 1);

    // Reset in the 4th ACCESS cycle, together with a ready from the slave
    strobe(3);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid_c%0d", c), 8'hF7, 3'd3, 1'b1, 1'b0, 1'b1);
      bus.s_as_  = 1'b1;
      bus.s_rdy_ = (c == 4) ? 8'hF7 : 8'hFF;
      if (c == 4) reset = 1'b0;
    end
    @(negedge clk);
    chk("rstmid_abort", 8'hFF, 3'd0, 1'b1, 1'b0, 1'b0);
    reset      = 1'b1;
    bus.s_rdy_ = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid_quiet%0d", c), 8'hFF, 3'd0, 1'b1, 1'b0, 1'b0);
    end

    // Randomized accesses, including absent slave and timeouts
    repeat (30) begin
      access(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, TMO + 3)), -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
